mem_io_target: RTL and testbench



---
 rtl/mem_io_target.sv | 124 ++++++++++++
 tb/tb_mem_io_target.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_target.sv
// Memory-side responder: word-wide RAM plus a 4-register timer block, 1-cycle registered reads.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses and adds the align_err output.
module mem_io_target #(
  parameter int          RAM_WORDS = 64,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        wr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        align_err,
`endif
  output logic        timer_irq
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  typedef enum logic [1:0] {
    REG_COUNT   = 2'd0,
    REG_COMPARE = 2'd1,
    REG_STATUS  = 2'd2,
    REG_CTRL    = 2'd3
  } io_reg_e;

  logic [31:0]      ram [RAM_WORDS];
  logic [31:0]      count;
  logic [31:0]      compare;
  logic             expired;
  logic             irq_en;
  logic             count_en;

  logic [IDX_W-1:0] idx;
  logic             ram_hit;
  logic             io_hit;
  logic             misalign;
  logic             ram_we;
  logic             io_we;
  io_reg_e          reg_sel;
  logic [31:0]      rd_data;
  logic             expire_set;
  logic             expire_clr;

  assign idx     = address[IDX_W+1:2];
  assign ram_hit = address < 32'(4 * RAM_WORDS);
  assign io_hit  = !ram_hit && (address[31:4] == IO_BASE[31:4]);
  assign reg_sel = io_reg_e'(address[3:2]);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = address[1:0] != 2'b00;
`else
  assign misalign = 1'b0;
`endif

  assign ram_we     = wr && ram_hit && !misalign;
  assign io_we      = wr && io_hit && !misalign;
  // COUNT is compared before any same-cycle write to it, so the match uses the old value.
  assign expire_set = count_en && (count == compare);
  assign expire_clr = io_we && (reg_sel == REG_STATUS) && data_in[0];
  assign timer_irq  = expired && irq_en;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    rd_data = 32'h0000_0000;
    if (!misalign) begin
      if (ram_hit) begin
        rd_data = ram[idx];
      end else if (io_hit) begin
        unique case (reg_sel)
          REG_COUNT:   rd_data = count;
          REG_COMPARE: rd_data = compare;
          REG_STATUS:  rd_data = {31'b0, expired};
          REG_CTRL:    rd_data = {30'b0, count_en, irq_en};
        endcase
      end
    end
  end

  // NOTE: the RAM array has no reset; only the write is blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      ram[idx] <= data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= 32'h0000_0000;
      count    <= 32'h0000_0000;
      compare  <= 32'hFFFF_FFFF;
      expired  <= 1'b0;
      irq_en   <= 1'b0;
      count_en <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
      align_err <= 1'b0;
`endif
    end else begin
      data_out <= rd_data;
`ifdef MEM_ALIGN_CHECK_EN
      align_err <= misalign;
`endif
      expired  <= expire_set || (expired && !expire_clr);

      if (io_we && reg_sel == REG_COUNT) begin
        count <= data_in;
      end else if (count_en) begin
        count <= count + 32'd1;
      end

      if (io_we && reg_sel == REG_COMPARE) begin
        compare <= data_in;
      end

      if (io_we && reg_sel == REG_CTRL) begin
        irq_en   <= data_in[0];
        count_en <= data_in[1];
      end
    end
  end

endmodule

// File: tb/tb_mem_io_target.sv
// Bench for mem_io_target: table of RAM/unmapped/IO vectors plus hand-written timer and reset
// sequences; expected read data is queued at drive time and popped after the clock edge.
module tb_mem_io_target;

  localparam logic [31:0] IO = 32'hFFFF_0000;
  localparam logic [31:0] R_COUNT   = IO + 32'h0;
  localparam logic [31:0] R_COMPARE = IO + 32'h4;
  localparam logic [31:0] R_STATUS  = IO + 32'h8;
  localparam logic [31:0] R_CTRL    = IO + 32'hC;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        wr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        timer_irq;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] din;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic        chk;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[20];

  mem_io_target dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .wr        (wr),
    .data_in   (data_in),
    .data_out  (data_out),
`ifdef MEM_ALIGN_CHECK_EN
    .align_err (align_err),
`endif
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one access at a negedge, queue its expectation, then compare after the posedge.
  task automatic step(input string name, input logic rst, input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic chk, input logic [31:0] exp);
    exp_t e;
    reset   = rst;
    address = a;
    wr      = w;
    data_in = d;
    e.name  = name;
    e.chk   = chk;
    e.data  = exp;
    e.err   = !rst && (a[1:0] != 2'b00);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    if (e.chk) check(e.name, data_out, e.data);
`ifdef MEM_ALIGN_CHECK_EN
    check({e.name, " align_err"}, {31'b0, align_err}, {31'b0, e.err});
`endif
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    step(name, 1'b0, a, 1'b0, 32'h0, 1'b1, exp);
  endtask

  task automatic wt(input string name, input logic [31:0] a, input logic [31:0] d,
                    input logic chk, input logic [31:0] exp);
    step(name, 1'b0, a, 1'b1, d, chk, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    check(name, {31'b0, timer_irq}, {31'b0, exp});
  endtask

  initial begin
    vecs[0]  = '{"w8",          32'h0000_0008, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{"r8",          32'h0000_0008, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{"r_unmapped",  32'h1000_0000, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{"w4a",         32'h0000_0004, 1'b1, 32'h1111_1111, 1'b0, 32'h0};
    vecs[4]  = '{"w4b_old",     32'h0000_0004, 1'b1, 32'h2222_2222, 1'b1, 32'h1111_1111};
    vecs[5]  = '{"r4",          32'h0000_0004, 1'b0, 32'h0,         1'b1, 32'h2222_2222};
    vecs[6]  = '{"w_unmapped",  32'h1000_0000, 1'b1, 32'h1234_5678, 1'b1, 32'h0};
    vecs[7]  = '{"r_unmapped2", 32'h1000_0000, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{"w_top",       32'h0000_00FC, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[9]  = '{"r_top",       32'h0000_00FC, 1'b0, 32'h0,         1'b1, 32'hA5A5_A5A5};
    vecs[10] = '{"w0",          32'h0000_0000, 1'b1, 32'h0,         1'b0, 32'h0};
    vecs[11] = '{"w_past_ram",  32'h0000_0100, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[12] = '{"r0_no_alias", 32'h0000_0000, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[13] = '{"r_unaligned", 32'h0000_000A, 1'b0, 32'h0,         1'b1,
                 ALIGN ? 32'h0 : 32'hDEAD_BEEF};
    vecs[14] = '{"w_unaligned", 32'h0000_0006, 1'b1, 32'h3333_3333, 1'b1,
                 ALIGN ? 32'h0 : 32'h2222_2222};
    vecs[15] = '{"r4_after",    32'h0000_0004, 1'b0, 32'h0,         1'b1,
                 ALIGN ? 32'h2222_2222 : 32'h3333_3333};
    vecs[16] = '{"r_ctrl_rst",  R_CTRL,        1'b0, 32'h0,         1'b1, 32'h2};
    vecs[17] = '{"r_cmp_rst",   R_COMPARE,     1'b0, 32'h0,         1'b1, 32'hFFFF_FFFF};
    vecs[18] = '{"r_stat_rst",  R_STATUS,      1'b0, 32'h0,         1'b1, 32'h0};
    vecs[19] = '{"r_io_past",   IO + 32'h10,   1'b0, 32'h0,         1'b1, 32'h0};

    reset = 1'b1; address = '0; wr = 1'b0; data_in = '0;
    @(negedge clk);
    step("reset", 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    chk_irq("reset irq", 1'b0);

    foreach (vecs[i])
      step(vecs[i].name, 1'b0, vecs[i].addr, vecs[i].wr, vecs[i].din, vecs[i].chk, vecs[i].exp);

    // Timer: freeze, load, arm, and watch expiry at COUNT == 5.
    wt("ctrl_off",   R_CTRL,    32'h0, 1'b1, 32'h2);
    wt("count_ld0",  R_COUNT,   32'h0, 1'b0, 32'h0);
    rd("count_hold0", R_COUNT, 32'h0);
    rd("count_hold1", R_COUNT, 32'h0);
    wt("cmp_wr5",    R_COMPARE, 32'h5, 1'b1, 32'hFFFF_FFFF);
    wt("ctrl_on",    R_CTRL,    32'h3, 1'b1, 32'h0);
    rd("count_0", R_COUNT, 32'h0);
    rd("count_1", R_COUNT, 32'h1);
    rd("stat_c2", R_STATUS, 32'h0);
    rd("stat_c3", R_STATUS, 32'h0);
    rd("stat_c4", R_STATUS, 32'h0);
    chk_irq("irq before match", 1'b0);
    rd("stat_c5", R_STATUS, 32'h0);
    chk_irq("irq after match", 1'b1);
    rd("stat_set", R_STATUS, 32'h1);
    chk_irq("irq held", 1'b1);
    wt("stat_w0",  R_STATUS, 32'h0, 1'b1, 32'h1);
    chk_irq("irq after w0", 1'b1);
    rd("stat_kept", R_STATUS, 32'h1);
    wt("stat_w1",  R_STATUS, 32'h1, 1'b1, 32'h1);
    chk_irq("irq cleared", 1'b0);
    rd("stat_clr", R_STATUS, 32'h0);

    // Expiry with irq disabled, then enabling the irq afterwards.
    wt("ctrl_cnt_only", R_CTRL,  32'h2, 1'b1, 32'h3);
    wt("count_ld5",     R_COUNT, 32'h5, 1'b1, 32'hC);
    rd("stat_pre", R_STATUS, 32'h0);
    chk_irq("irq masked", 1'b0);
    rd("stat_masked", R_STATUS, 32'h1);
    chk_irq("irq still masked", 1'b0);
    wt("ctrl_irq_on", R_CTRL, 32'h3, 1'b1, 32'h2);
    chk_irq("irq unmasked", 1'b1);
    wt("stat_clr2", R_STATUS, 32'h1, 1'b1, 32'h1);
    chk_irq("irq cleared2", 1'b0);

    // Set and clear in the same cycle: set wins.
    wt("count_ld4", R_COUNT, 32'h4, 1'b1, 32'h9);
    rd("count_4", R_COUNT, 32'h4);
    wt("stat_clr_vs_set", R_STATUS, 32'h1, 1'b1, 32'h0);
    rd("stat_set_wins", R_STATUS, 32'h1);
    chk_irq("irq set wins", 1'b1);

    // Write COUNT while it matches: old value matches, loaded value is kept.
    wt("stat_clr3",   R_STATUS, 32'h1,   1'b1, 32'h1);
    wt("count_ld5b",  R_COUNT,  32'h5,   1'b1, 32'h8);
    wt("count_ld100", R_COUNT,  32'h100, 1'b1, 32'h5);
    rd("count_100", R_COUNT, 32'h100);
    rd("stat_wr_match", R_STATUS, 32'h1);

    // Wrap-around and hold.
    wt("count_ldfe", R_COUNT, 32'hFFFF_FFFE, 1'b1, 32'h102);
    rd("count_fe",  R_COUNT, 32'hFFFF_FFFE);
    rd("count_ff",  R_COUNT, 32'hFFFF_FFFF);
    rd("count_w0",  R_COUNT, 32'h0);
    rd("count_w1",  R_COUNT, 32'h1);
    wt("ctrl_off2", R_CTRL, 32'h0, 1'b1, 32'h3);
    chk_irq("irq ctrl off", 1'b0);
    rd("count_h3a", R_COUNT, 32'h3);
    rd("count_h3b", R_COUNT, 32'h3);

    // Reset during a write to 0x10.
    wt("w10", 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 32'h0);
    step("reset_wr", 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0BAD, 1'b1, 32'h0);
    chk_irq("reset_wr irq", 1'b0);
    rd("post_rst_count",  R_COUNT, 32'h0);
    rd("post_rst_w10",    32'h0000_0010, 32'hCAFE_F00D);
    rd("post_rst_ctrl",   R_CTRL, 32'h2);
    rd("post_rst_status", R_STATUS, 32'h0);
    rd("post_rst_cmp",    R_COMPARE, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
